uart_period_parser: RTL and testbench
=====================================

UART_PERIOD_PARSER -- requirements
Module: uart_period_parser

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 5, max decimal digits accepted per command.
REQ-002 SHALL have parameter PERIOD_MIN, default 100, smallest accepted period value.
REQ-003 SHALL have parameter PERIOD_MAX, default 50000, largest accepted period value.
REQ-004 SHALL have parameter DEFAULT_PERIOD, default 1600, period value after reset.
REQ-005 SHALL have port clk1  input  1  system clock; all logic on rising edge; one clock only.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port rx_data  input  8  received UART byte, valid only while rx_valid=1.
REQ-008 SHALL have port rx_valid  input  1  one-cycle strobe per received byte.
REQ-009 SHALL have port tx_busy  input  1  UART transmitter busy; a byte is accepted only when 0.
REQ-010 SHALL have port period  output  16  current sine-step period fed to the PWM sine stage.
REQ-011 SHALL have port period_valid  output  1  one-cycle strobe when period changes.
REQ-012 SHALL have port err  output  1  one-cycle strobe on a rejected command.
REQ-013 SHALL have port tx_data  output  8  acknowledge byte.
REQ-014 SHALL have port tx_en  output  1  one-cycle transmit request.

Function
REQ-015 SHALL implement FSM states IDLE and NUM, with a 17-bit accumulator acc and a digit counter.
REQ-016 IDLE: byte 'P' (0x50) -> NUM, acc=0, count=0; any other byte is ignored and stays IDLE.
REQ-017 NUM, digit '0'..'9' (0x30..0x39): acc = acc*10 + digit, count+1; acc saturates at 0x1FFFF.
REQ-018 NUM, a digit arriving when count==MAX_DIGITS -> reject.
REQ-019 NUM, byte 'P' -> restart: acc=0, count=0, stay in NUM, no err.
REQ-020 NUM, CR (0x0D) or LF (0x0A) with count==0 -> reject.
REQ-021 NUM, CR/LF with PERIOD_MIN<=acc<=PERIOD_MAX -> accept.
REQ-022 NUM, CR/LF with acc outside [PERIOD_MIN, PERIOD_MAX] -> reject.
REQ-023 NUM, any other byte -> reject.
REQ-024 On accept, period<=acc[15:0] and period_valid=1 on the cycle after the terminating rx_valid; FSM -> IDLE.
REQ-025 On reject, err=1 on the cycle after the offending rx_valid; period unchanged; FSM -> IDLE.
REQ-026 period_valid and err SHALL never both be 1 in the same cycle, and each SHALL be high for exactly one cycle.
REQ-027 Cycles without rx_valid SHALL NOT change FSM state or acc; there is no timeout.

Reset
REQ-028 With rst=1 at a clock edge: FSM=IDLE, acc=0, count=0, period=DEFAULT_PERIOD, period_valid=0, err=0, tx_en=0, tx_data=0, ack pending cleared.
REQ-029 rst SHALL override a simultaneous rx_valid; a partially received command is discarded.

Configuration
REQ-030 With macro UART_PERIOD_PARSER_ACK_EN defined, an accept queues ack byte 'K' (0x4B) and a reject queues 'E' (0x45) in a one-entry pending register.
REQ-031 With UART_PERIOD_PARSER_ACK_EN defined, tx_en=1 for one cycle with tx_data=the pending byte when the pending register is full and tx_busy=0; pending clears on that cycle.
REQ-032 With UART_PERIOD_PARSER_ACK_EN defined, a new ack arriving while one is still pending overwrites it (latest wins); parsing continues while an ack is pending.
REQ-033 Without UART_PERIOD_PARSER_ACK_EN, tx_en and tx_data SHALL be constant 0, no ack logic is built, and all other behaviour is identical.

Verification
REQ-034 Reset, then "P825\r" with tx_busy=0 -> period=825, one period_valid pulse; with ACK_EN, tx_en pulse with tx_data=0x4B.
REQ-035 "P99\n" (below min), then "P60000\r", then "P\r" -> three err pulses, period stays 1600; with ACK_EN, three 0x45 bytes.
REQ-036 "P123456\r" (6 digits) -> err on the 6th digit; the trailing '\r' is ignored in IDLE; period unchanged.
REQ-037 "P12P415\r" and "xyzP237\r" -> period=415 then 237, no err pulses.
REQ-038 rst asserted after "P41" is received, then "5\r" -> period=1600, no period_valid, no err.
REQ-039 With ACK_EN and tx_busy=1, send two accepted commands -> no tx_en while busy; after tx_busy falls, exactly one tx_en with 0x4B.

Source files
------------

// File: rtl/uart_period_parser.sv
// Parses "P<digits><CR|LF>" commands from a UART byte stream into a PWM sine-step period.
// Optional acknowledge bytes ('K' accept / 'E' reject) are built only when UART_PERIOD_PARSER_ACK_EN is defined.
module uart_period_parser #(
    parameter int MAX_DIGITS     = 5,
    parameter int PERIOD_MIN     = 100,
    parameter int PERIOD_MAX     = 50000,
    parameter int DEFAULT_PERIOD = 1600
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        tx_busy,
    output logic [15:0] period,
    output logic        period_valid,
    output logic        err,
    output logic [7:0]  tx_data,
    output logic        tx_en
);

    localparam int          CW      = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);
    localparam logic [16:0] MIN17   = 17'(PERIOD_MIN);
    localparam logic [16:0] MAX17   = 17'(PERIOD_MAX);
    localparam logic [7:0]  CH_P    = 8'h50;
    localparam logic [7:0]  CH_CR   = 8'h0D;
    localparam logic [7:0]  CH_LF   = 8'h0A;

    typedef enum logic {IDLE, NUM} state_t;

    state_t        state, state_next;
    logic [16:0]   acc, acc_next;
    logic [CW-1:0] count, count_next;
    logic          accept, reject;
    logic          is_digit, is_eol;
    logic [20:0]   acc_mul;

    always_ff @(posedge clk1) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= 17'd0;
            count        <= '0;
            period       <= 16'(DEFAULT_PERIOD);
            period_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_next;
            acc          <= acc_next;
            count        <= count_next;
            period_valid <= accept;
            err          <= reject;
            if (accept) begin
                period <= acc[15:0];
            end
        end
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        count_next = count;
        accept     = 1'b0;
        reject     = 1'b0;
        is_digit   = (rx_data >= 8'h30) && (rx_data <= 8'h39);
        is_eol     = (rx_data == CH_CR) || (rx_data == CH_LF);
        // Wide product so the saturation test sees the true value.
        acc_mul    = 21'(acc) * 21'd10 + 21'(rx_data[3:0]);

        if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (rx_data == CH_P) begin
                        state_next = NUM;
                        acc_next   = 17'd0;
                        count_next = '0;
                    end
                end
                NUM: begin
                    if (rx_data == CH_P) begin
                        acc_next   = 17'd0;
                        count_next = '0;
                    end else if (is_digit) begin
                        if (count == MAX_CNT) begin
                            reject = 1'b1;
                        end else begin
                            acc_next   = (acc_mul > 21'h1FFFF) ? 17'h1FFFF : acc_mul[16:0];
                            count_next = count + CW'(1);
                        end
                    end else if (is_eol) begin
                        if (count == '0) begin
                            reject = 1'b1;
                        end else if ((acc >= MIN17) && (acc <= MAX17)) begin
                            accept = 1'b1;
                        end else begin
                            reject = 1'b1;
                        end
                    end else begin
                        reject = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
            if (accept || reject) begin
                state_next = IDLE;
            end
        end
    end

`ifdef UART_PERIOD_PARSER_ACK_EN
    logic       pend_full;
    logic [7:0] pend_byte;

    // A fresh ack outranks the clear from a byte leaving in the same cycle.
    always_ff @(posedge clk1) begin
        if (rst) begin
            pend_full <= 1'b0;
            pend_byte <= 8'h00;
        end else begin
            if (tx_en) begin
                pend_full <= 1'b0;
            end
            if (accept) begin
                pend_full <= 1'b1;
                pend_byte <= 8'h4B;
            end else if (reject) begin
                pend_full <= 1'b1;
                pend_byte <= 8'h45;
            end
        end
    end

    assign tx_en   = pend_full && !tx_busy;
    assign tx_data = tx_en ? pend_byte : 8'h00;
`else
    logic unused_tx_busy;
    assign unused_tx_busy = tx_busy;
    assign tx_en          = 1'b0;
    assign tx_data        = 8'h00;
`endif

endmodule

// File: tb/tb_uart_period_parser.sv
// Self-checking bench for uart_period_parser: directed command scenarios plus randomized byte streams
// compared against a digit-queue reference model; ack checks follow UART_PERIOD_PARSER_ACK_EN.
module tb_uart_period_parser;

    localparam int         MAX_DIGITS     = 5;
    localparam int         PERIOD_MIN     = 100;
    localparam int         PERIOD_MAX     = 50000;
    localparam int         DEFAULT_PERIOD = 1600;
    localparam logic [7:0] CR             = 8'h0D;
    localparam logic [7:0] LF             = 8'h0A;

    logic        clk1;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_busy;
    logic [15:0] period;
    logic        period_valid;
    logic        err;
    logic [7:0]  tx_data;
    logic        tx_en;

    int checkCount;
    int errorCount;

    bit         modelInCmd;
    int         modelDigits[$];
    int         modelPeriod;
    bit         modelPendFull;
    logic [7:0] modelPendByte;

    uart_period_parser #(
        .MAX_DIGITS(MAX_DIGITS),
        .PERIOD_MIN(PERIOD_MIN),
        .PERIOD_MAX(PERIOD_MAX),
        .DEFAULT_PERIOD(DEFAULT_PERIOD)
    ) dut (
        .clk1(clk1),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .tx_busy(tx_busy),
        .period(period),
        .period_valid(period_valid),
        .err(err),
        .tx_data(tx_data),
        .tx_en(tx_en)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Reference model: the command is a list of decimal digits evaluated only at the terminator.
    task automatic modelByte(input logic [7:0] b, output bit evAcc, output bit evRej);
        longint value;
        evAcc = 1'b0;
        evRej = 1'b0;
        if (!modelInCmd) begin
            if (b == 8'h50) begin
                modelInCmd = 1'b1;
                modelDigits.delete();
            end
        end else if (b == 8'h50) begin
            modelDigits.delete();
        end else if (b >= 8'h30 && b <= 8'h39) begin
            if (modelDigits.size() == MAX_DIGITS) evRej = 1'b1;
            else modelDigits.push_back(int'(b) - 48);
        end else if (b == CR || b == LF) begin
            if (modelDigits.size() == 0) begin
                evRej = 1'b1;
            end else begin
                value = 0;
                foreach (modelDigits[i]) value = value * 10 + modelDigits[i];
                if (value > 131071) value = 131071;
                if (value >= PERIOD_MIN && value <= PERIOD_MAX) begin
                    evAcc = 1'b1;
                    modelPeriod = int'(value);
                end else begin
                    evRej = 1'b1;
                end
            end
        end else begin
            evRej = 1'b1;
        end
        if (evAcc || evRej) modelInCmd = 1'b0;
    endtask

    // One clock edge, then every output is compared at the following falling edge.
    task automatic tick(input bit evAcc, input bit evRej);
`ifdef UART_PERIOD_PARSER_ACK_EN
        if (modelPendFull && !tx_busy) modelPendFull = 1'b0;
        if (evAcc) begin
            modelPendFull = 1'b1;
            modelPendByte = 8'h4B;
        end else if (evRej) begin
            modelPendFull = 1'b1;
            modelPendByte = 8'h45;
        end
`endif
        @(negedge clk1);
        checkOutput("period_valid", 32'(period_valid), 32'(evAcc));
        checkOutput("err", 32'(err), 32'(evRej));
        checkOutput("period", 32'(period), 32'(modelPeriod));
`ifdef UART_PERIOD_PARSER_ACK_EN
        checkOutput("tx_en", 32'(tx_en), 32'(modelPendFull && !tx_busy));
        if (modelPendFull && !tx_busy) checkOutput("tx_data", 32'(tx_data), 32'(modelPendByte));
`else
        checkOutput("tx_en", 32'(tx_en), 32'd0);
        checkOutput("tx_data", 32'(tx_data), 32'd0);
`endif
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        bit evAcc, evRej;
        rx_data  = b;
        rx_valid = 1'b1;
        modelByte(b, evAcc, evRej);
        tick(evAcc, evRej);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) tick(1'b0, 1'b0);
    endtask

    task automatic sendString(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) applyStimulus(s[i], gap);
    endtask

    task automatic doReset(input bit withByte);
        rst = 1'b1;
        if (withByte) begin
            rx_valid = 1'b1;
            rx_data  = 8'h35;
        end
        @(negedge clk1);
        rst      = 1'b0;
        rx_valid = 1'b0;
        modelInCmd = 1'b0;
        modelDigits.delete();
        modelPeriod = DEFAULT_PERIOD;
        modelPendFull = 1'b0;
        checkOutput("rst_period", 32'(period), 32'(DEFAULT_PERIOD));
        checkOutput("rst_period_valid", 32'(period_valid), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_tx_en", 32'(tx_en), 32'd0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
    endtask

    initial begin
        int         v;
        int         sel;
        int         gap;
        string      s;
        logic [7:0] term;

        checkCount = 0;
        errorCount = 0;
        rst        = 1'b1;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        tx_busy    = 1'b0;
        @(negedge clk1);
        doReset(1'b0);

        sendString("P825", 1);
        applyStimulus(CR, 1);
        checkOutput("req034_period", 32'(period), 32'd825);

        doReset(1'b0);
        sendString("P99", 0);
        applyStimulus(LF, 1);
        sendString("P60000", 0);
        applyStimulus(CR, 2);
        sendString("P", 0);
        applyStimulus(CR, 1);
        sendString("P123456", 1);
        applyStimulus(CR, 1);
        checkOutput("req036_period", 32'(period), 32'd1600);

        sendString("P12P415", 0);
        applyStimulus(CR, 1);
        checkOutput("req037_first", 32'(period), 32'd415);
        sendString("xyzP237", 1);
        applyStimulus(CR, 1);
        checkOutput("req037_second", 32'(period), 32'd237);

        sendString("P100", 0);
        applyStimulus(CR, 1);
        checkOutput("min_edge", 32'(period), 32'd100);
        sendString("P50000", 0);
        applyStimulus(LF, 1);
        checkOutput("max_edge", 32'(period), 32'd50000);
        sendString("P50001", 0);
        applyStimulus(CR, 1);
        checkOutput("above_max", 32'(period), 32'd50000);

        sendString("P41", 1);
        doReset(1'b1);
        sendString("5", 1);
        applyStimulus(CR, 1);
        checkOutput("req038_period", 32'(period), 32'd1600);

        for (int n = 0; n < 300; n++) begin
            gap     = $urandom_range(0, 2);
            tx_busy = ($urandom_range(0, 3) == 0);
            sel     = $urandom_range(0, 11);
            if (sel == 0) begin
                applyStimulus(8'($urandom), gap);
            end else if (sel == 1) begin
                doReset($urandom_range(0, 1) == 1);
            end else begin
                case ($urandom_range(0, 6))
                    0: v = 99;
                    1: v = 100;
                    2: v = 50000;
                    3: v = 50001;
                    4: v = $urandom_range(100, 50000);
                    default: v = $urandom_range(0, 99999);
                endcase
                s = $sformatf("%0d", v);
                if (sel == 2) s = {s, "7"};
                if (sel == 3 && s.len() < MAX_DIGITS) s = {"0", s};
                if (sel == 4) s = "";
                sendString({"P", s}, gap);
                case ($urandom_range(0, 5))
                    0, 1: term = CR;
                    2, 3: term = LF;
                    4:    term = 8'h78;
                    default: term = 8'h00;
                endcase
                if (term != 8'h00) applyStimulus(term, gap);
            end
        end
        tx_busy = 1'b0;
        tick(1'b0, 1'b0);

`ifdef UART_PERIOD_PARSER_ACK_EN
        doReset(1'b0);
        tx_busy = 1'b1;
        sendString("P200", 0);
        applyStimulus(CR, 1);
        sendString("P300", 0);
        applyStimulus(LF, 2);
        tx_busy = 1'b0;
        #1;
        checkOutput("busy_release_en", 32'(tx_en), 32'd1);
        checkOutput("busy_release_data", 32'(tx_data), 32'h4B);
        tick(1'b0, 1'b0);
        checkOutput("busy_single_pulse", 32'(tx_en), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
